serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 19 +
 rtl/full_adder.sv | 19 +
 rtl/serial_adder.sv | 137 +++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module : serial_adder_pkg
// Shared FSM encoding and default sizing for serial_adder.
// Rev    : 1.0
// ============================================================================
package serial_adder_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_DIGIT = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module : full_adder
// One-bit full adder cell.
// Rev    : 1.0
// ============================================================================
module full_adder (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic sum,
   output logic carry_out
);

   assign sum       = a ^ b ^ c_in;
   assign carry_out = (a & b) | (c_in & (a ^ b));

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module : serial_adder
// Digit-serial adder, DIGIT bits per cycle; SERIAL_ADDER_OVF_EN adds ovf.
// Rev    : 1.0
// ============================================================================
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DIGIT = DEFAULT_DIGIT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             out_valid,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int            N    = WIDTH / DIGIT;
   localparam int            CW   = $clog2(N + 1);
   localparam logic [CW-1:0] LAST = CW'(N - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   state_t           r_state;
   state_t           w_state_next;
   logic             w_accept;
   logic             w_last;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] w_a_next;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_c_out;
   logic [CW-1:0]    r_cnt;
   logic [DIGIT:0]   w_c;
   logic [DIGIT-1:0] w_dsum;

   assign in_ready  = (r_state != RUN);
   assign out_valid = (r_state == DONE);
   assign w_accept  = in_valid && in_ready;
   assign w_last    = (r_cnt == LAST);
   assign sum       = r_sum;
   assign c_out     = r_c_out;

   assign w_c[0] = r_carry;

   generate
      for (genvar i = 0; i < DIGIT; i++) begin : g_fa
         full_adder u_fa (
            .a         (r_a[i]),
            .b         (r_b[i]),
            .c_in      (w_c[i]),
            .sum       (w_dsum[i]),
            .carry_out (w_c[i+1])
         );
      end
   endgenerate

   // Operand A doubles as the result shift register: each digit sum enters
   // at the top as the consumed digit leaves at the bottom.
   generate
      if (WIDTH > DIGIT) begin : g_shift
         assign w_a_next = {w_dsum, r_a[WIDTH-1:DIGIT]};
      end else begin : g_single
         assign w_a_next = w_dsum;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE:    if (w_accept) w_state_next = RUN;
         RUN:     if (w_last) w_state_next = DONE;
         DONE:    w_state_next = w_accept ? RUN : IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_c_out <= 1'b0;
         r_cnt   <= '0;
      end else if (w_accept) begin
         r_a     <= a;
         r_b     <= b;
         r_carry <= c_in;
         r_cnt   <= '0;
      end else if (r_state == RUN) begin
         r_a     <= w_a_next;
         r_b     <= r_b >> DIGIT;
         r_carry <= w_c[DIGIT];
         r_cnt   <= r_cnt + ONE;
         if (w_last) begin
            r_sum   <= w_a_next;
            r_c_out <= w_c[DIGIT];
         end
      end
   end

`ifdef SERIAL_ADDER_OVF_EN
   logic r_ovf;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (r_state == RUN && w_last) begin
         r_ovf <= w_c[DIGIT-1] ^ w_c[DIGIT];
      end
   end

   assign ovf = r_ovf;
`endif

endmodule
`default_nettype wire
